// File: rtl/key_debounce_scan_pkg.sv
// Shared types and constants for the pushbutton debounce front end.
package key_debounce_scan_pkg;

    // Per-key debounce FSM states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } key_state_e;

    localparam int unsigned CLK_FREQ_HZ = 200_000_000;

    // Converts a duration in milliseconds to clk cycles at CLK_FREQ_HZ.
    function automatic int unsigned ms_to_cycles(input int unsigned ms);
        return ms * (CLK_FREQ_HZ / 1000);
    endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One key: 2-FF synchroniser, polarity normalisation, debounce FSM,
// debounce counter and long-press hold counter. Outputs are registered.
//
// state     | meaning
// ----------|------------------------------------------------------------
// IDLE      | key released and accepted as released
// PRESS_CHK | press seen, waiting for DEBOUNCE_CYCLES of stable press
// HELD      | press accepted, hold counter running
// REL_CHK   | release seen, waiting for DEBOUNCE_CYCLES of stable release
module key_debounce_cell
    import key_debounce_scan_pkg::*;
#(
    parameter int KEY_ACTIVE_LOW    = 1,
    parameter int DEBOUNCE_CYCLES   = 4_000_000,
    parameter int LONG_PRESS_CYCLES = 200_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int CNT_MAX = (LONG_PRESS_CYCLES > DEBOUNCE_CYCLES) ? LONG_PRESS_CYCLES : DEBOUNCE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] LP_LAST = CW'(LONG_PRESS_CYCLES - 1);
    // Hold counter parks one past LP_LAST so key_long fires once per hold.
    localparam logic [CW-1:0] LP_SAT  = CW'(LONG_PRESS_CYCLES);
    localparam logic          REL_LVL = (KEY_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic          sync_1, sync_2, pressed;
    key_state_e    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [CW-1:0] hold_cnt, hold_nxt;
    logic          level_nxt, press_nxt, release_nxt, long_nxt;

    // Two-flop synchroniser, preloaded with the released level on reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_1 <= REL_LVL;
            sync_2 <= REL_LVL;
        end else begin
            sync_1 <= key_in;
            sync_2 <= sync_1;
        end
    end

    assign pressed = sync_2 ^ REL_LVL;

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            hold_cnt    <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            hold_cnt    <= hold_nxt;
            key_level   <= level_nxt;
            key_press   <= press_nxt;
            key_release <= release_nxt;
            key_long    <= long_nxt;
        end
    end

    // Next-state, counter updates and event detection
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        hold_nxt    = hold_cnt;
        level_nxt   = key_level;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        long_nxt    = 1'b0;

        // Hold time keeps accruing through release bounces
        if (state == HELD || state == REL_CHK) begin
            if (hold_cnt != LP_SAT) begin
                hold_nxt = hold_cnt + 1'b1;
            end
            long_nxt = (hold_cnt == LP_LAST);
        end

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (pressed) begin
                    state_nxt = PRESS_CHK;
                end
            end
            PRESS_CHK: begin
                if (!pressed) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                    hold_nxt  = '0;
                    press_nxt = 1'b1;
                    level_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!pressed) begin
                    state_nxt = REL_CHK;
                    cnt_nxt   = '0;
                end
            end
            REL_CHK: begin
                if (pressed) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nxt   = IDLE;
                    cnt_nxt     = '0;
                    release_nxt = 1'b1;
                    level_nxt   = 1'b0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/key_debounce_scan.sv
// Pushbutton front end: one independent debounce cell per key.
module key_debounce_scan
    import key_debounce_scan_pkg::*;
#(
    parameter int NUM_KEYS          = 4,
    parameter int KEY_ACTIVE_LOW    = 1,
    parameter int DEBOUNCE_CYCLES   = int'(ms_to_cycles(20)),
    parameter int LONG_PRESS_CYCLES = int'(ms_to_cycles(1000))
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce_cell #(
            .KEY_ACTIVE_LOW   (KEY_ACTIVE_LOW),
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
        ) u_cell (
            .clk        (clk),
            .rst_n      (rst_n),
            .key_in     (key_in[k]),
            .key_level  (key_level[k]),
            .key_press  (key_press[k]),
            .key_release(key_release[k]),
            .key_long   (key_long[k])
        );
    end

endmodule

// File: tb/tb_key_debounce_scan.sv
// Bench for key_debounce_scan with short debounce/long-press timing.
// Event timing: an input driven just after edge c is first sampled at edge
// c+1; the pulse is registered DEBOUNCE_CYCLES+2 edges later, at edge c+LAT.
module tb_key_debounce_scan;

    localparam int NK  = 4;
    localparam int DB  = 8;
    localparam int LP  = 32;
    localparam int LAT = DB + 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NK-1:0] key_in;
    logic [NK-1:0] key_level, key_press, key_release, key_long;

    int cyc    = 0;
    int n_cmp  = 0;
    int n_bad  = 0;

    typedef struct {
        int         cyc;
        logic [3:0] pr;
        logic [3:0] rl;
        logic [3:0] lg;
    } ev_t;

    ev_t sb[$];
    logic [3:0] m_ep, m_er, m_el;

    key_debounce_scan #(
        .NUM_KEYS         (NK),
        .KEY_ACTIVE_LOW   (1),
        .DEBOUNCE_CYCLES  (DB),
        .LONG_PRESS_CYCLES(LP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_in     (key_in),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every cycle, pulses due now are popped and compared; any
    // unscheduled pulse is also a mismatch.
    always @(negedge clk) begin
        m_ep = '0;
        m_er = '0;
        m_el = '0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                m_ep = m_ep | sb[i].pr;
                m_er = m_er | sb[i].rl;
                m_el = m_el | sb[i].lg;
                sb.delete(i);
            end
        end
        if ((m_ep | m_er | m_el) != 4'b0 || (key_press | key_release | key_long) !== 4'b0) begin
            n_cmp++;
            if (key_press !== m_ep || key_release !== m_er || key_long !== m_el) begin
                n_bad++;
                $display("FAIL pulses cyc=%0d press got %b want %b, release got %b want %b, long got %b want %b",
                         cyc, key_press, m_ep, key_release, m_er, key_long, m_el);
            end
        end
    end

    task automatic push(input int c, input logic [3:0] pr, input logic [3:0] rl, input logic [3:0] lg);
        ev_t e;
        e.cyc = c;
        e.pr  = pr;
        e.rl  = rl;
        e.lg  = lg;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step(1);
    endtask

    task automatic test_reset();
        int c;
        rst_n  = 1'b0;
        key_in = 4'h0;
        step(3);
        n_cmp++;
        if (key_level !== 4'h0 || key_press !== 4'h0 || key_release !== 4'h0 || key_long !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_outputs level=%b press=%b release=%b long=%b want all 0",
                     key_level, key_press, key_release, key_long);
        end
        c = cyc;
        rst_n = 1'b1;
        push(c + LAT, 4'hF, 4'h0, 4'h0);
        wait_until(c + LAT - 1);
        n_cmp++;
        if (key_level !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_prequal_level got %b want 0000", key_level);
        end
        step(1);
        n_cmp++;
        if (key_level !== 4'hF) begin
            n_bad++;
            $display("FAIL reset_press_level got %b want 1111", key_level);
        end
        c = cyc;
        key_in = 4'hF;
        push(c + LAT, 4'h0, 4'hF, 4'h0);
        wait_until(c + LAT);
        n_cmp++;
        if (key_level !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_release_level got %b want 0000", key_level);
        end
        step(4);
    endtask

    task automatic test_clean_press();
        int c, p;
        c = cyc;
        key_in[0] = 1'b0;
        p = c + LAT;
        push(p, 4'h1, 4'h0, 4'h0);
        push(p + LP, 4'h0, 4'h0, 4'h1);
        wait_until(p);
        n_cmp++;
        if (key_level !== 4'h1) begin
            n_bad++;
            $display("FAIL clean_press_level got %b want 0001", key_level);
        end
        wait_until(p + LP + 6);
        c = cyc;
        key_in[0] = 1'b1;
        push(c + LAT, 4'h0, 4'h1, 4'h0);
        wait_until(c + LAT - 1);
        n_cmp++;
        if (key_level !== 4'h1) begin
            n_bad++;
            $display("FAIL clean_release_early_level got %b want 0001", key_level);
        end
        step(1);
        n_cmp++;
        if (key_level !== 4'h0) begin
            n_bad++;
            $display("FAIL clean_release_level got %b want 0000", key_level);
        end
        step(4);
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 30; i++) begin
            key_in[1] = (((i / 3) % 2) == 0) ? 1'b0 : 1'b1;
            step(1);
            n_cmp++;
            if (key_level[1] !== 1'b0) begin
                n_bad++;
                $display("FAIL bounce_level cyc=%0d got %b want 0", cyc, key_level[1]);
            end
        end
        key_in[1] = 1'b1;
        for (int i = 0; i < LAT + 2; i++) begin
            step(1);
            n_cmp++;
            if (key_level[1] !== 1'b0) begin
                n_bad++;
                $display("FAIL bounce_settle_level cyc=%0d got %b want 0", cyc, key_level[1]);
            end
        end
    endtask

    task automatic test_release_bounce();
        int c, p;
        c = cyc;
        key_in[1] = 1'b0;
        p = c + LAT;
        push(p, 4'h2, 4'h0, 4'h0);
        push(p + LP, 4'h0, 4'h0, 4'h2);
        wait_until(p + 4);
        key_in[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            n_cmp++;
            if (key_level[1] !== 1'b1) begin
                n_bad++;
                $display("FAIL rel_bounce_level cyc=%0d got %b want 1", cyc, key_level[1]);
            end
        end
        key_in[1] = 1'b0;
        wait_until(p + LP);
        n_cmp++;
        if (key_level !== 4'h2) begin
            n_bad++;
            $display("FAIL rel_bounce_hold_level got %b want 0010", key_level);
        end
        step(3);
        c = cyc;
        key_in[1] = 1'b1;
        push(c + LAT, 4'h0, 4'h2, 4'h0);
        wait_until(c + LAT);
        n_cmp++;
        if (key_level !== 4'h0) begin
            n_bad++;
            $display("FAIL rel_bounce_final_level got %b want 0000", key_level);
        end
        step(4);
    endtask

    task automatic test_independence();
        int c, p;
        c = cyc;
        key_in[3:2] = 2'b00;
        p = c + LAT;
        push(p, 4'hC, 4'h0, 4'h0);
        wait_until(p + 2);
        n_cmp++;
        if (key_level !== 4'hC) begin
            n_bad++;
            $display("FAIL indep_press_level got %b want 1100", key_level);
        end
        c = cyc;
        key_in[3] = 1'b1;
        push(c + LAT, 4'h0, 4'h8, 4'h0);
        push(p + LP, 4'h0, 4'h0, 4'h4);
        wait_until(c + LAT);
        n_cmp++;
        if (key_level !== 4'h4) begin
            n_bad++;
            $display("FAIL indep_release3_level got %b want 0100", key_level);
        end
        wait_until(p + LP + 2);
        c = cyc;
        key_in[2] = 1'b1;
        push(c + LAT, 4'h0, 4'h4, 4'h0);
        wait_until(c + LAT);
        n_cmp++;
        if (key_level !== 4'h0) begin
            n_bad++;
            $display("FAIL indep_release2_level got %b want 0000", key_level);
        end
        step(4);
    endtask

    task automatic test_reset_mid_hold();
        int c, p;
        c = cyc;
        key_in[0] = 1'b0;
        p = c + LAT;
        push(p, 4'h1, 4'h0, 4'h0);
        wait_until(p + 3);
        rst_n = 1'b0;
        step(1);
        n_cmp++;
        if (key_level !== 4'h0 || key_press !== 4'h0 || key_release !== 4'h0 || key_long !== 4'h0) begin
            n_bad++;
            $display("FAIL midhold_reset_outputs level=%b press=%b release=%b long=%b want all 0",
                     key_level, key_press, key_release, key_long);
        end
        c = cyc;
        rst_n = 1'b1;
        push(c + LAT, 4'h1, 4'h0, 4'h0);
        wait_until(c + LAT - 1);
        n_cmp++;
        if (key_level !== 4'h0) begin
            n_bad++;
            $display("FAIL midhold_requal_level got %b want 0000", key_level);
        end
        step(1);
        n_cmp++;
        if (key_level !== 4'h1) begin
            n_bad++;
            $display("FAIL midhold_repress_level got %b want 0001", key_level);
        end
        c = cyc;
        key_in[0] = 1'b1;
        push(c + LAT, 4'h0, 4'h1, 4'h0);
        wait_until(c + LAT);
        n_cmp++;
        if (key_level !== 4'h0) begin
            n_bad++;
            $display("FAIL midhold_release_level got %b want 0000", key_level);
        end
        step(4);
    endtask

    initial begin
        rst_n  = 1'b0;
        key_in = 4'h0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_bounce();
        test_independence();
        test_reset_mid_hold();
        step(LP + 4);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain got %0d pending events want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
